// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter and sequencer for the single data-memory port.
// One access per two cycles: IDLE samples and latches a winner, ACCESS drives memory.
module dmem_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sext,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_size,
    input  logic        dma_sext,
    input  logic        dma_lock,
    output logic        cpu_gnt,
    output logic        dma_gnt,
    output logic        cpu_rvalid,
    output logic        dma_rvalid,
    output logic [31:0] cpu_rdata,
    output logic [31:0] dma_rdata,
    output logic        cpu_err,
    output logic        dma_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    output logic [1:0]  mem_size,
    output logic        mem_sext,
    input  logic [31:0] mem_rdata,
    output logic        owner
);

    localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_port;
    logic             r_we;
    logic             r_sext;
    logic             r_err;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [1:0]       r_size;
    logic             r_owner;
    logic [CNT_W-1:0] r_burst;
    logic             r_cpu_gnt;
    logic             r_dma_gnt;
    logic             r_cpu_rvalid;
    logic             r_dma_rvalid;
    logic [31:0]      r_cpu_rdata;
    logic [31:0]      r_dma_rdata;
    logic             r_cpu_err;
    logic             r_dma_err;

    logic             w_any_req;
    logic             w_dma_wins;
    logic             w_sel_we;
    logic             w_sel_sext;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [1:0]       w_sel_size;
    logic             w_sel_err;
    logic [CNT_W-1:0] w_burst_sat;
    logic [31:0]      w_resp_data;

    function automatic logic f_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   f_bad_access = 1'b0;
            2'b01:   f_bad_access = addr_lo[0];
            2'b10:   f_bad_access = (addr_lo != 2'b00);
            default: f_bad_access = 1'b1;
        endcase
    endfunction

    assign w_any_req = cpu_req | dma_req;

    // Burst lock only extends a DMA run; otherwise contention alternates away from owner.
    always_comb begin
        if (cpu_req && !dma_req) begin
            w_dma_wins = 1'b0;
        end else if (dma_req && !cpu_req) begin
            w_dma_wins = 1'b1;
        end else if (dma_lock && r_owner && (r_burst < MAX_BURST_C)) begin
            w_dma_wins = 1'b1;
        end else begin
            w_dma_wins = !r_owner;
        end
    end

    assign w_sel_we    = w_dma_wins ? dma_we    : cpu_we;
    assign w_sel_sext  = w_dma_wins ? dma_sext  : cpu_sext;
    assign w_sel_addr  = w_dma_wins ? dma_addr  : cpu_addr;
    assign w_sel_wdata = w_dma_wins ? dma_wdata : cpu_wdata;
    assign w_sel_size  = w_dma_wins ? dma_size  : cpu_size;
    assign w_sel_err   = f_bad_access(w_sel_size, w_sel_addr[1:0]);

    assign w_burst_sat = (r_burst >= MAX_BURST_C) ? MAX_BURST_C : (r_burst + CNT_W'(1));
    assign w_resp_data = (r_we || r_err) ? 32'd0 : mem_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_sext       <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_owner      <= 1'b0;
            r_burst      <= '0;
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_cpu_err    <= 1'b0;
            r_dma_err    <= 1'b0;
        end else begin
            r_cpu_gnt    <= 1'b0;
            r_dma_gnt    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_ACCESS;
                        r_port    <= w_dma_wins;
                        r_owner   <= w_dma_wins;
                        r_we      <= w_sel_we;
                        r_sext    <= w_sel_sext;
                        r_addr    <= w_sel_addr;
                        r_wdata   <= w_sel_wdata;
                        r_size    <= w_sel_size;
                        r_err     <= w_sel_err;
                        r_cpu_gnt <= !w_dma_wins;
                        r_dma_gnt <= w_dma_wins;
                        if (w_dma_wins) begin
                            r_burst <= dma_lock ? w_burst_sat : CNT_W'(1);
                        end else begin
                            r_burst <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state <= S_IDLE;
                    if (r_port) begin
                        r_dma_rvalid <= 1'b1;
                        r_dma_rdata  <= w_resp_data;
                        r_dma_err    <= r_err;
                    end else begin
                        r_cpu_rvalid <= 1'b1;
                        r_cpu_rdata  <= w_resp_data;
                        r_cpu_err    <= r_err;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from registered state so they fall with reset.
    assign mem_write  = (r_state == S_ACCESS) && r_we && !r_err;
    assign mem_read   = (r_state == S_ACCESS) && !r_we && !r_err;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_size   = r_size;
    assign mem_sext   = r_sext;

    assign owner      = r_owner;
    assign cpu_gnt    = r_cpu_gnt;
    assign dma_gnt    = r_dma_gnt;
    assign cpu_rvalid = r_cpu_rvalid;
    assign dma_rvalid = r_dma_rvalid;
    assign cpu_rdata  = r_cpu_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign cpu_err    = r_cpu_err;
    assign dma_err    = r_dma_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: 256-byte behavioural memory, transaction-level reference
// model of arbitration, error rules and memory contents, directed cases then random traffic.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sext = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [1:0]  cpu_size = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0, dma_sext = 1'b0, dma_lock = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic [1:0]  dma_size = '0;
    logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read, mem_sext, owner;
    logic [1:0]  mem_size;

    always #5 clock = ~clock;

    dmem_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_size(cpu_size), .cpu_sext(cpu_sext),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_size(dma_size), .dma_sext(dma_sext), .dma_lock(dma_lock),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
        .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata), .cpu_err(cpu_err), .dma_err(dma_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
        .mem_size(mem_size), .mem_sext(mem_sext), .mem_rdata(mem_rdata), .owner(owner)
    );

    // Behavioural memory: little-endian bytes, combinational sized/extended read.
    logic [7:0]  mem [0:255];
    logic [31:0] mem_word;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) % 256);
        mem[16] = 8'hEF; mem[17] = 8'hBE; mem[18] = 8'hAD; mem[19] = 8'hDE;
        forever begin
            @(posedge clock);
            if (mem_write) begin
                mem[mem_addr[7:0]] = mem_wdata[7:0];
                if (mem_size != 2'b00) mem[mem_addr[7:0] + 8'd1] = mem_wdata[15:8];
                if (mem_size == 2'b10) begin
                    mem[mem_addr[7:0] + 8'd2] = mem_wdata[23:16];
                    mem[mem_addr[7:0] + 8'd3] = mem_wdata[31:24];
                end
            end
        end
    end

    always_comb begin
        mem_word = {mem[mem_addr[7:0] + 8'd3], mem[mem_addr[7:0] + 8'd2],
                    mem[mem_addr[7:0] + 8'd1], mem[mem_addr[7:0]]};
        case (mem_size)
            2'b00:   mem_rdata = mem_sext ? {{24{mem_word[7]}}, mem_word[7:0]} : {24'd0, mem_word[7:0]};
            2'b01:   mem_rdata = mem_sext ? {{16{mem_word[15]}}, mem_word[15:0]} : {16'd0, mem_word[15:0]};
            2'b10:   mem_rdata = mem_word;
            default: mem_rdata = 32'd0;
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct packed {
        bit        gc, gd, mw, mr;
        bit [31:0] addr;
        bit        rc, rd, err;
        bit [31:0] data;
    } slot_t;

    slot_t       s1, s2;
    bit          m_acc, m_owner, rand_mode;
    int          m_burst;
    logic [7:0]  ref_mem [0:255];
    logic [31:0] last_c_data, last_d_data;
    logic        last_c_err, last_d_err;

    function automatic bit ref_bad(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        int unsigned v = 0;
        int n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int k = 0; k < n; k++) v += int'(ref_mem[(a + k) % 256]) << (8 * k);
        if (sx && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic decide();
        bit          win, bad;
        logic        we, sx;
        logic [31:0] a, wd;
        logic [1:0]  sz;
        if (m_acc) begin
            m_acc = 1'b0;
            return;
        end
        if (!cpu_req && !dma_req) return;
        if (cpu_req && dma_req)
            win = (dma_lock && m_owner && m_burst < MAX_BURST) ? 1'b1 : !m_owner;
        else
            win = dma_req;
        if (win) m_burst = dma_lock ? ((m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1) : 1;
        else     m_burst = 0;
        m_owner = win;
        m_acc   = 1'b1;
        we = win ? dma_we    : cpu_we;
        a  = win ? dma_addr  : cpu_addr;
        wd = win ? dma_wdata : cpu_wdata;
        sz = win ? dma_size  : cpu_size;
        sx = win ? dma_sext  : cpu_sext;
        bad = ref_bad(a, sz);
        s1.gc = !win; s1.gd = win; s1.addr = a;
        s1.mw = we && !bad; s1.mr = !we && !bad;
        s2.rc = !win; s2.rd = win; s2.err = bad;
        s2.data = (bad || we) ? 32'd0 : ref_load(a, sz, sx);
        if (!bad && we) begin
            ref_mem[a % 256] = wd[7:0];
            if (sz != 2'b00) ref_mem[(a + 1) % 256] = wd[15:8];
            if (sz == 2'b10) begin
                ref_mem[(a + 2) % 256] = wd[23:16];
                ref_mem[(a + 3) % 256] = wd[31:24];
            end
        end
    endtask

    task automatic rnd_fields(output logic we, output logic [31:0] a, output logic [31:0] wd,
                              output logic [1:0] sz, output logic sx);
        we = 1'($urandom_range(0, 1));
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        a  = $urandom_range(0, 255);
        if ($urandom_range(0, 3) != 0) a = (sz == 2'b01) ? (a & 32'hFE) : (sz == 2'b10) ? (a & 32'hFC) : a;
        wd = $urandom;
        sx = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        slot_t cur;
        decide();
        @(posedge clock);
        #1;
        cur = s1; s1 = s2; s2 = '0;
        if (cur.rc) begin last_c_data = cur.data; last_c_err = cur.err; end
        if (cur.rd) begin last_d_data = cur.data; last_d_err = cur.err; end
        chk("cpu_gnt", cpu_gnt, cur.gc);
        chk("dma_gnt", dma_gnt, cur.gd);
        chk("mem_write", mem_write, cur.mw);
        chk("mem_read", mem_read, cur.mr);
        if (cur.gc || cur.gd) chk("mem_addr", mem_addr, cur.addr);
        chk("cpu_rvalid", cpu_rvalid, cur.rc);
        chk("dma_rvalid", dma_rvalid, cur.rd);
        chk("cpu_rdata", cpu_rdata, last_c_data);
        chk("cpu_err", cpu_err, last_c_err);
        chk("dma_rdata", dma_rdata, last_d_data);
        chk("dma_err", dma_err, last_d_err);
        chk("owner", owner, m_owner);
        if (cur.gc) cpu_req = 1'b0;
        if (cur.gd) dma_req = 1'b0;
        if (rand_mode) begin
            if (!cpu_req && $urandom_range(0, 1) == 1) begin
                rnd_fields(cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_sext);
                cpu_req = 1'b1;
            end
            if (!dma_req && $urandom_range(0, 1) == 1) begin
                rnd_fields(dma_we, dma_addr, dma_wdata, dma_size, dma_sext);
                dma_req = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) dma_lock = !dma_lock;
        end
    endtask

    task automatic reset_model();
        s1 = '0; s2 = '0;
        m_acc = 1'b0; m_owner = 1'b0; m_burst = 0;
        last_c_data = '0; last_d_data = '0; last_c_err = 1'b0; last_d_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         seq [$];
        bit         exp_seq [6];
        logic [7:0] saved [4];
        logic [7:0] old5;
        int         guard;

        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'((i * 37 + 11) % 256);
        ref_mem[16] = 8'hEF; ref_mem[17] = 8'hBE; ref_mem[18] = 8'hAD; ref_mem[19] = 8'hDE;
        reset_model();
        rand_mode = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_owner", owner, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        step(); step();

        // CPU word load
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_size = 2'b10; cpu_sext = 0;
        step(); chk("ld_gnt", cpu_gnt, 1);
        step(); chk("ld_rvalid", cpu_rvalid, 1);
        chk("ld_data", cpu_rdata, 32'hDEADBEEF);
        chk("ld_err", cpu_err, 0);

        // Contention: DMA first, then CPU two cycles later
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; cpu_size = 2'b10;
        dma_req = 1; dma_we = 0; dma_addr = 32'h24; dma_size = 2'b10; dma_lock = 0;
        step(); chk("cont_dgnt", dma_gnt, 1); chk("cont_own1", owner, 1);
        step();
        step(); chk("cont_cgnt", cpu_gnt, 1); chk("cont_own0", owner, 0);
        step();

        // Burst lock: 4 DMA grants, then the CPU, then DMA again
        dma_lock = 1;
        for (int i = 0; i < 12; i++) begin
            if (!cpu_req) cpu_req = 1;
            if (!dma_req) dma_req = 1;
            step();
            if (dma_gnt) seq.push_back(1'b1);
            if (cpu_gnt) seq.push_back(1'b0);
        end
        chk("burst_len", seq.size(), 6);
        for (int i = 0; i < 6 && i < seq.size(); i++) chk($sformatf("burst_seq%0d", i), seq[i], exp_seq[i]);
        guard = 0;
        while ((cpu_req || dma_req) && guard < 10) begin step(); guard++; end
        chk("burst_drain", guard < 10, 1);
        dma_lock = 0;
        step(); step();

        // Misaligned CPU word store; illegal-size DMA load
        for (int k = 0; k < 4; k++) saved[k] = mem[8'h22 + k];
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h22; cpu_size = 2'b10; cpu_wdata = 32'h12345678;
        step(); step();
        chk("mis_err", cpu_err, 1);
        chk("mis_rdata", cpu_rdata, 0);
        for (int k = 0; k < 4; k++) chk("mis_mem", mem[8'h22 + k], saved[k]);
        dma_req = 1; dma_we = 0; dma_addr = 32'h30; dma_size = 2'b11;
        step(); step();
        chk("ill_err", dma_err, 1);
        chk("ill_rdata", dma_rdata, 0);

        // DMA halfword store then CPU sign-extended halfword load
        dma_req = 1; dma_we = 1; dma_addr = 32'h42; dma_size = 2'b01; dma_wdata = 32'h0000_8001;
        step(); step();
        chk("st_err", dma_err, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h42; cpu_size = 2'b01; cpu_sext = 1;
        step(); step();
        chk("sext_data", cpu_rdata, 32'hFFFF8001);

        // Random traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 1500; i++) step();
        rand_mode = 1'b0;
        guard = 0;
        while ((cpu_req || dma_req) && guard < 40) begin step(); guard++; end
        chk("rand_drain", guard < 40, 1);
        step(); step();

        // Reset during the ACCESS cycle of a byte store
        old5 = mem[5];
        dma_req = 1; dma_we = 1; dma_addr = 32'h05; dma_size = 2'b00; dma_wdata = 32'hAA; dma_lock = 0;
        step();
        chk("rm_gnt", dma_gnt, 1);
        chk("rm_mw_before", mem_write, 1);
        #2 reset_n = 1'b0;
        #1 chk("rm_mw_drop", mem_write, 0);
        dma_req = 1'b0;
        @(posedge clock);
        #1;
        chk("rm_rvalid", dma_rvalid, 0);
        chk("rm_mem5", mem[5], old5);
        chk("rm_owner", owner, 0);
        ref_mem[5] = old5;
        @(negedge clock);
        reset_n = 1'b1;
        reset_model();
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the byte-addressable data memory.
- Shares the single memory port between the CPU load/store unit (port C) and the ASCON accelerator DMA (port D).
- Latches each request, drives the memory control signals for exactly one cycle, and returns a registered response with misalignment/size error flagging.
- Round-robin arbitration, with a bounded DMA burst lock.

Parameters:
- MAX_BURST, 4, maximum consecutive DMA grants under dma_lock while the CPU is waiting (must be ≥1).
- CNT_W, 3, width of the burst counter; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req / dma_req  in  1  request; held stable with all its fields until the matching gnt pulse.
- cpu_we / dma_we  in  1  1 = store, 0 = load.
- cpu_addr / dma_addr  in  32  byte address.
- cpu_wdata / dma_wdata  in  32  store data, right-aligned.
- cpu_size / dma_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- cpu_sext / dma_sext  in  1  sign-extend loads.
- dma_lock  in  1  DMA requests burst priority.
- cpu_gnt / dma_gnt  out  1  one-cycle acceptance pulse.
- cpu_rvalid / dma_rvalid  out  1  one-cycle response pulse.
- cpu_rdata / dma_rdata  out  32  load result; 0 for stores and errors.
- cpu_err / dma_err  out  1  error flag, valid with rvalid.
- mem_addr  out  32  to memory.
- mem_wdata  out  32  to memory.
- mem_write  out  1  to memory.
- mem_read  out  1  to memory.
- mem_size  out  2  to memory.
- mem_sext  out  1  to memory.
- mem_rdata  in  32  combinational read data from memory.
- owner  out  1  owner of the current or last access (0 = CPU, 1 = DMA).

Behaviour:
- Reset state:
  - FSM in IDLE.
  - All outputs 0; owner = 0 (so the first contended grant goes to DMA).
  - burst_cnt = 0; latched request cleared.
  - mem_write and mem_read drop immediately on reset assertion (they are decoded from the registered state).
- FSM states:
  - IDLE: if any request is pending, latch the winner's fields and go to ACCESS; otherwise stay.
  - ACCESS: always go to IDLE. A new request is sampled only in IDLE, so throughput is at most one access per 2 cycles.
- Cycle timing:
  - Edge N: a request is sampled in IDLE.
  - Cycle N+1 (ACCESS):
    - mem_* outputs are driven from the latched fields.
    - mem_read = !we, mem_write = we, unless an error is flagged (see error rules), in which case both stay 0.
    - The winner's gnt is high for this cycle only; the requester may change or drop its request afterwards.
    - Stores commit at the end of N+1.
    - mem_rdata is captured at the end of N+1.
  - Cycle N+2: winner's rvalid = 1, plus rdata and err.
  - Load-to-response latency is 2 cycles from the sampling edge.
- Arbitration in IDLE (evaluated in order):
  - Only one request pending: that port wins.
  - Both pending, dma_lock = 1, owner = DMA and burst_cnt < MAX_BURST: DMA wins.
  - Otherwise, both pending: the port that is not owner wins (round-robin).
- Burst counter:
  - On a DMA grant with dma_lock = 1: burst_cnt increments, saturating at MAX_BURST.
  - On a CPU grant, or dma_lock = 0 at the DMA grant: burst_cnt resets to 1 for a DMA grant, 0 for a CPU grant.
  - With the CPU idle, the DMA may continue indefinitely.
- Error rules:
  - Error conditions: size = 11; halfword with addr[0] = 1; word with addr[1:0] ≠ 00.
  - On error: no memory access, rdata = 0, err = 1, and gnt and rvalid still pulse.
- Store responses: rvalid pulses as an acknowledgement, with rdata = 0 and err = 0.
- mem_addr, mem_wdata, mem_size and mem_sext are held at their last value outside ACCESS; only read/write are gated.
- rdata and err hold their value after rvalid falls, until the next response to that port.
- Request dropped before gnt: protocol violation, no required behaviour.
- Reset asserted during ACCESS: the access is abandoned, no rvalid is issued, and the store is not committed if reset lands before the edge.

Test Plan:
- CPU load: cpu_req with addr 0x10, size 10, memory word 0xDEADBEEF → cpu_gnt 1 cycle after the sampling edge; cpu_rvalid 1 cycle later with cpu_rdata = 0xDEADBEEF and err = 0.
- Contention from reset: both request simultaneously → DMA granted first (owner reset 0), then CPU on the next IDLE; grants 2 cycles apart; owner toggles 1, 0.
- Burst lock: dma_lock = 1, DMA requesting continuously, CPU requesting throughout → exactly 4 consecutive dma_gnt, then cpu_gnt, then DMA resumes with burst_cnt = 1.
- Misalignment: CPU word store to 0x22 → mem_write never asserted; cpu_rvalid with cpu_err = 1 and cpu_rdata = 0; memory unchanged. Illegal size 11 on DMA → same behaviour on dma_err.
- Store then load: DMA halfword store 0x8001 to 0x42, then CPU halfword load with sext = 1 from 0x42 → cpu_rdata = 0xFFFF8001.
- Reset mid-operation: reset_n low during ACCESS of a store of 0xAA to 0x05 → mem_write drops immediately; no rvalid; byte 0x05 unchanged; after release, outputs are 0 and the FSM is in IDLE.
